// File: rtl/ecc_scrub_pkg.sv
// Shared types for the ECC patrol scrubber: FSM state encoding and the bit
// positions of the external decoder's error flags.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        ScrubIdle,
        ScrubWait,
        ScrubRead,
        ScrubCheck,
        ScrubWrite
    } scrub_state_e;

    localparam int unsigned ErrCorrBit   = 0;
    localparam int unsigned ErrUncorrBit = 1;

endpackage

// File: rtl/ecc_scrub_timer.sv
// Loadable down-counter that paces patrol reads; stops at zero and flags it.
module ecc_scrub_timer #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (load_i) begin
            count_reg <= load_val_i;
        end else if (dec_i && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero_o = (count_reg == '0);

endmodule

// File: rtl/ecc_patrol_scrubber.sv
// Background ECC patrol: walks the bank one word at a time in idle cycles,
// writes back corrected words and logs/counts uncorrectable ones.
module ecc_patrol_scrubber
    import ecc_scrub_pkg::*;
#(
    parameter int BankSize      = 256,
    parameter int DataWidth     = 39,
    parameter int IntervalWidth = 16,
    parameter int CntWidth      = 16,
    localparam int AddrW        = (BankSize > 1) ? $clog2(BankSize) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic                     trigger_i,
    input  logic                     intc_req_i,
    input  logic                     intc_we_i,
    input  logic [AddrW-1:0]         intc_add_i,
    input  logic [DataWidth-1:0]     intc_wdata_i,
    output logic [DataWidth-1:0]     intc_rdata_o,
    output logic                     bank_req_o,
    output logic                     bank_we_o,
    output logic [AddrW-1:0]         bank_add_o,
    output logic [DataWidth-1:0]     bank_wdata_o,
    input  logic [DataWidth-1:0]     bank_rdata_i,
    output logic [DataWidth-1:0]     ecc_out_o,
    input  logic [DataWidth-1:0]     ecc_in_i,
    input  logic [1:0]               ecc_err_i,
    output logic                     corrected_o,
    output logic                     uncorrectable_o,
    output logic                     pass_done_o,
    output logic [CntWidth-1:0]      corr_cnt_o,
    output logic [CntWidth-1:0]      uncorr_cnt_o,
    output logic [AddrW-1:0]         last_uncorr_add_o,
    input  logic                     clear_i
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(BankSize - 1);

    scrub_state_e          state_reg, state_next;
    logic [AddrW-1:0]      addr_reg;
    logic [DataWidth-1:0]  data_reg, fix_reg;
    logic [CntWidth-1:0]   corr_cnt_reg, uncorr_cnt_reg;
    logic [AddrW-1:0]      last_uncorr_reg;
    logic                  corrected_reg, uncorrectable_reg, pass_done_reg;

    logic timer_load, timer_dec, timer_zero;
    logic scrub_req, scrub_we, addr_inc, corr_evt, uncorr_evt;
    logic collision;

    ecc_scrub_timer #(.Width(IntervalWidth)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (interval_i),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    assign collision = intc_req_i & intc_we_i & (intc_add_i == addr_reg);

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        scrub_req  = 1'b0;
        scrub_we   = 1'b0;
        addr_inc   = 1'b0;
        corr_evt   = 1'b0;
        uncorr_evt = 1'b0;
        case (state_reg)
            ScrubIdle: begin
                if (trigger_i) begin
                    state_next = ScrubRead;
                end else if (enable_i) begin
                    timer_load = 1'b1;
                    state_next = ScrubWait;
                end
            end
            ScrubWait: begin
                if (trigger_i) begin
                    state_next = ScrubRead;
                end else if (!enable_i) begin
                    state_next = ScrubIdle;
                end else if (timer_zero) begin
                    state_next = ScrubRead;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ScrubRead: begin
                scrub_req = 1'b1;
                if (!intc_req_i) begin
                    state_next = ScrubCheck;
                end
            end
            ScrubCheck: begin
                if (ecc_err_i[ErrUncorrBit]) begin
                    uncorr_evt = 1'b1;
                    addr_inc   = 1'b1;
                    state_next = ScrubIdle;
                end else if (ecc_err_i[ErrCorrBit] && !collision) begin
                    state_next = ScrubWrite;
                end else begin
                    // Clean word, or the host is overwriting it right now.
                    addr_inc   = 1'b1;
                    state_next = ScrubIdle;
                end
            end
            ScrubWrite: begin
                if (collision) begin
                    addr_inc   = 1'b1;
                    state_next = ScrubIdle;
                end else if (!intc_req_i) begin
                    scrub_req  = 1'b1;
                    scrub_we   = 1'b1;
                    corr_evt   = 1'b1;
                    addr_inc   = 1'b1;
                    state_next = ScrubIdle;
                end
            end
            default: state_next = ScrubIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= ScrubIdle;
            addr_reg          <= '0;
            data_reg          <= '0;
            fix_reg           <= '0;
            corrected_reg     <= 1'b0;
            uncorrectable_reg <= 1'b0;
            pass_done_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            corrected_reg     <= corr_evt;
            uncorrectable_reg <= uncorr_evt;
            pass_done_reg     <= addr_inc & (addr_reg == LastAddr);
            if (state_reg == ScrubCheck) begin
                data_reg <= bank_rdata_i;
                fix_reg  <= ecc_in_i;
            end
            if (addr_inc) begin
                addr_reg <= (addr_reg == LastAddr) ? '0 : addr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_reg    <= '0;
            uncorr_cnt_reg  <= '0;
            last_uncorr_reg <= '0;
        end else if (clear_i) begin
            corr_cnt_reg    <= '0;
            uncorr_cnt_reg  <= '0;
            last_uncorr_reg <= '0;
        end else begin
            if (corr_evt && (corr_cnt_reg != '1)) begin
                corr_cnt_reg <= corr_cnt_reg + 1'b1;
            end
            if (uncorr_evt) begin
                last_uncorr_reg <= addr_reg;
                if (uncorr_cnt_reg != '1) begin
                    uncorr_cnt_reg <= uncorr_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Read data arrives during Check, so the decoder sees it directly there;
    // afterwards the captured copy holds while the bank is shared with the host.
    assign ecc_out_o = (state_reg == ScrubCheck) ? bank_rdata_i : data_reg;

    assign bank_req_o   = intc_req_i | scrub_req;
    assign bank_we_o    = intc_req_i ? intc_we_i    : scrub_we;
    assign bank_add_o   = intc_req_i ? intc_add_i   : addr_reg;
    assign bank_wdata_o = intc_req_i ? intc_wdata_i : fix_reg;
    assign intc_rdata_o = bank_rdata_i;

    assign corrected_o       = corrected_reg;
    assign uncorrectable_o   = uncorrectable_reg;
    assign pass_done_o       = pass_done_reg;
    assign corr_cnt_o        = corr_cnt_reg;
    assign uncorr_cnt_o      = uncorr_cnt_reg;
    assign last_uncorr_add_o = last_uncorr_reg;

endmodule
